// File: rtl/led_pwm_dev_if.sv
// Bus interface for the LED PWM peripheral: 16-bit 68000-style local bus with
// upper/lower byte strobes, a read/write select and a registered acknowledge.
//   data_write : write data, [15:8] even byte, [7:0] odd byte
//   data_read  : registered read data
//   addr       : byte address within the block (addr[0] ignored)
//   uds / lds  : upper / lower byte strobes
//   rw         : 1 = read, 0 = write
//   ack        : registered acknowledge, one cycle after a strobe
interface led_pwm_dev_if;
  logic [15:0] data_write;
  logic [15:0] data_read;
  logic [7:0]  addr;
  logic        uds;
  logic        lds;
  logic        rw;
  logic        ack;

  modport master (
    output data_write, addr, uds, lds, rw,
    input  data_read, ack
  );

  modport slave (
    input  data_write, addr, uds, lds, rw,
    output data_read, ack
  );
endinterface

// File: rtl/led_pwm_dev.sv
// LED PWM peripheral: NUM_LEDS channels, each with enable, PWM brightness and
// an optional blink gate. One shared prescaler drives a single PWM counter;
// frame wraps drive a blink phase toggle. Duty values are double-buffered and
// move into the shadow copies only at frame boundaries.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of led_pwm_dev_if
//   leds    : registered LED drive, 1 = on
module led_pwm_dev #(
  parameter int unsigned NUM_LEDS = 8,
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  led_pwm_dev_if.slave        bus,
  output logic [NUM_LEDS-1:0] leds
);

  typedef logic [PWM_BITS-1:0] duty_t;

  localparam duty_t      DutyMax    = '1;
  localparam logic [6:0] WEnable    = 7'h00;
  localparam logic [6:0] WBlink     = 7'h01;
  localparam logic [6:0] WPrescale  = 7'h02;
  localparam logic [6:0] WBlinkPer  = 7'h03;
  localparam logic [6:0] WStatus    = 7'h04;

  logic [NUM_LEDS-1:0] enable_q, enable_d;
  logic [NUM_LEDS-1:0] blink_q, blink_d;
  logic [NUM_LEDS-1:0] leds_q, leds_d;
  logic [15:0]         prescale_q, prescale_d;
  logic [15:0]         blink_period_q, blink_period_d;
  logic [15:0]         pre_cnt_q, pre_cnt_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic [15:0]         data_read_q, data_read_d;
  duty_t               pwm_cnt_q, pwm_cnt_d;
  duty_t               duty_q [NUM_LEDS];
  duty_t               duty_d [NUM_LEDS];
  duty_t               shadow_q [NUM_LEDS];
  duty_t               shadow_d [NUM_LEDS];
  logic                pending_q, pending_d;
  logic                phase_q, phase_d;
  logic                ack_q, ack_d;

  logic                strobe, wr, rd;
  logic [6:0]          word;
  logic [15:0]         lane_mask;
  logic                tick, frame_end;
  logic [NUM_LEDS-1:0] duty_sel;
  logic                duty_write;
  logic [15:0]         rdata;
  logic                unused_addr0;

  function automatic logic [15:0] merge(input logic [15:0] old_v, input logic [15:0] new_v,
                                        input logic [15:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  assign strobe       = bus.uds | bus.lds;
  assign wr           = strobe & ~bus.rw;
  assign rd           = strobe & bus.rw;
  assign word         = bus.addr[7:1];
  assign unused_addr0 = bus.addr[0];
  assign lane_mask    = {{8{bus.uds}}, {8{bus.lds}}};
  assign tick         = (pre_cnt_q == prescale_q);
  assign frame_end    = tick && (pwm_cnt_q == DutyMax);

  // DUTY[i] lives at word 8 + i; words past NUM_LEDS decode to nothing.
  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++) begin
      duty_sel[i] = (word == 7'(8 + i));
    end
  end

  assign duty_write = wr & (|duty_sel);

  always_comb begin
    rdata = '0;
    case (word)
      WEnable:   rdata = 16'(enable_q);
      WBlink:    rdata = 16'(blink_q);
      WPrescale: rdata = prescale_q;
      WBlinkPer: rdata = blink_period_q;
      WStatus:   rdata = {14'd0, pending_q, phase_q};
      default: begin
        for (int i = 0; i < NUM_LEDS; i++) begin
          if (duty_sel[i]) rdata = 16'(duty_q[i]);
        end
      end
    endcase
  end

  always_comb begin
    ack_d          = strobe;
    data_read_d    = rd ? (rdata & lane_mask) : 16'd0;
    enable_d       = enable_q;
    blink_d        = blink_q;
    prescale_d     = prescale_q;
    blink_period_d = blink_period_q;
    duty_d         = duty_q;
    shadow_d       = shadow_q;
    pending_d      = pending_q;
    pre_cnt_d      = pre_cnt_q;
    pwm_cnt_d      = pwm_cnt_q;
    frame_cnt_d    = frame_cnt_q;
    phase_d        = phase_q;
    leds_d         = '0;

    if (wr) begin
      case (word)
        WEnable:   enable_d = NUM_LEDS'(merge(16'(enable_q), bus.data_write, lane_mask));
        WBlink:    blink_d = NUM_LEDS'(merge(16'(blink_q), bus.data_write, lane_mask));
        WPrescale: prescale_d = merge(prescale_q, bus.data_write, lane_mask);
        WBlinkPer: blink_period_d = merge(blink_period_q, bus.data_write, lane_mask);
        default: begin
          for (int i = 0; i < NUM_LEDS; i++) begin
            if (duty_sel[i]) begin
              duty_d[i] = PWM_BITS'(merge(16'(duty_q[i]), bus.data_write, lane_mask));
            end
          end
        end
      endcase
    end

    // A PRESCALE write restarts the prescaler so the new rate starts cleanly.
    if (wr && (word == WPrescale)) begin
      pre_cnt_d = '0;
    end else if (tick) begin
      pre_cnt_d = '0;
    end else begin
      pre_cnt_d = pre_cnt_q + 16'd1;
    end

    if (tick) pwm_cnt_d = pwm_cnt_q + 1'b1;

    // Shadows take the pre-edge DUTY values, so a write landing on the
    // frame_end edge waits for the next frame and keeps pending set.
    if (frame_end) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        shadow_d[i] = duty_q[i];
      end
    end

    if (duty_write) begin
      pending_d = 1'b1;
    end else if (frame_end) begin
      pending_d = 1'b0;
    end

    if (blink_period_q == 16'd0) begin
      phase_d     = 1'b1;
      frame_cnt_d = '0;
    end else if (frame_end) begin
      if (frame_cnt_q == blink_period_q) begin
        phase_d     = ~phase_q;
        frame_cnt_d = '0;
      end else begin
        frame_cnt_d = frame_cnt_q + 16'd1;
      end
    end

    for (int i = 0; i < NUM_LEDS; i++) begin
      leds_d[i] = enable_q[i] &
                  ((shadow_q[i] == DutyMax) | (pwm_cnt_q < shadow_q[i])) &
                  (~blink_q[i] | phase_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q          <= 1'b0;
      data_read_q    <= '0;
      enable_q       <= '0;
      blink_q        <= '0;
      prescale_q     <= '0;
      blink_period_q <= '0;
      duty_q         <= '{default: '0};
      shadow_q       <= '{default: '0};
      pending_q      <= 1'b0;
      pre_cnt_q      <= '0;
      pwm_cnt_q      <= '0;
      frame_cnt_q    <= '0;
      phase_q        <= 1'b0;
      leds_q         <= '0;
    end else begin
      ack_q          <= ack_d;
      data_read_q    <= data_read_d;
      enable_q       <= enable_d;
      blink_q        <= blink_d;
      prescale_q     <= prescale_d;
      blink_period_q <= blink_period_d;
      duty_q         <= duty_d;
      shadow_q       <= shadow_d;
      pending_q      <= pending_d;
      pre_cnt_q      <= pre_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      frame_cnt_q    <= frame_cnt_d;
      phase_q        <= phase_d;
      leds_q         <= leds_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.data_read = data_read_q;
  assign leds          = leds_q;

endmodule
